// File: rtl/round_timer_ctrl.sv
// Game-round countdown controller: loads a clamped start value as BCD, counts down on
// divider ticks, supports pause/resume, and restarts the seconds divider on (re)start.
module round_timer_ctrl #(
    parameter int MAX_SEC  = 99,
    parameter int WARN_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic       div_clear,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic [6:0] load_sec,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       paused,
    output logic       warn,
    output logic       timeout,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    state_t     r_state;
    logic [3:0] r_tens, r_ones;
    logic       r_div_clear, r_timeout, r_running, r_paused, r_warn, r_done;

    state_t     w_state_n;
    logic [3:0] w_tens_n, w_ones_n;
    logic       w_div_clear_n, w_timeout_n, w_warn_n;
    logic [6:0] w_load_val, w_cnt_n;
    logic [7:0] w_load_bcd;
    logic       w_tick_ok, w_cnt_is_one, w_cnt_is_zero;

    assign w_load_val    = (load_sec > 7'(MAX_SEC)) ? 7'(MAX_SEC) : load_sec;
    assign w_load_bcd    = to_bcd(w_load_val);
    // A tick coinciding with the divider restart belongs to the aborted period.
    assign w_tick_ok     = tick && !r_div_clear;
    assign w_cnt_is_one  = (r_tens == 4'd0) && (r_ones == 4'd1);
    assign w_cnt_is_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_cnt_n       = ({3'd0, w_tens_n} * 7'd10) + {3'd0, w_ones_n};

    // Next-state, next-count and next-output decode
    always_comb begin
        w_state_n     = r_state;
        w_tens_n      = r_tens;
        w_ones_n      = r_ones;
        w_div_clear_n = 1'b0;
        w_timeout_n   = 1'b0;
        if (start) begin
            if (w_load_val != 7'd0) begin
                w_state_n     = ST_RUN;
                w_tens_n      = w_load_bcd[7:4];
                w_ones_n      = w_load_bcd[3:0];
                w_div_clear_n = 1'b1;
            end else begin
                w_state_n   = ST_DONE;
                w_tens_n    = 4'd0;
                w_ones_n    = 4'd0;
                w_timeout_n = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_n = ST_IDLE;
                end
                ST_RUN: begin
                    if (w_tick_ok && w_cnt_is_one) begin
                        w_tens_n    = 4'd0;
                        w_ones_n    = 4'd0;
                        w_state_n   = ST_DONE;
                        w_timeout_n = 1'b1;
                    end else begin
                        if (w_tick_ok && !w_cnt_is_zero) begin
                            if (r_ones == 4'd0) begin
                                w_ones_n = 4'd9;
                                w_tens_n = r_tens - 4'd1;
                            end else begin
                                w_ones_n = r_ones - 4'd1;
                            end
                        end else begin
                            w_ones_n = r_ones;
                        end
                        if (pause_toggle) begin
                            w_state_n = ST_PAUSE;
                        end else begin
                            w_state_n = ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_toggle) begin
                        w_state_n     = ST_RUN;
                        w_div_clear_n = 1'b1;
                    end else begin
                        w_state_n = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    w_tens_n = 4'd0;
                    w_ones_n = 4'd0;
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_tens_n  = 4'd0;
                    w_ones_n  = 4'd0;
                end
            endcase
        end
        if (((w_state_n == ST_RUN) || (w_state_n == ST_PAUSE)) &&
            (w_cnt_n != 7'd0) && (w_cnt_n <= 7'(WARN_SEC))) begin
            w_warn_n = 1'b1;
        end else begin
            w_warn_n = 1'b0;
        end
    end

    // State, count and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_div_clear <= 1'b0;
            r_timeout   <= 1'b0;
            r_running   <= 1'b0;
            r_paused    <= 1'b0;
            r_warn      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_tens      <= w_tens_n;
            r_ones      <= w_ones_n;
            r_div_clear <= w_div_clear_n;
            r_timeout   <= w_timeout_n;
            r_running   <= (w_state_n == ST_RUN);
            r_paused    <= (w_state_n == ST_PAUSE);
            r_warn      <= w_warn_n;
            r_done      <= (w_state_n == ST_DONE);
        end
    end

    assign sec_tens  = r_tens;
    assign sec_ones  = r_ones;
    assign div_clear = r_div_clear;
    assign timeout   = r_timeout;
    assign running   = r_running;
    assign paused    = r_paused;
    assign warn      = r_warn;
    assign done      = r_done;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl: a behavioural model pushes the expected
// outputs each cycle and they are popped and compared once the DUT has updated.
module tb_round_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause_toggle = 1'b0;
    logic [6:0] load_sec = 7'd0;
    logic       div_clear, running, paused, warn, timeout, done;
    logic [3:0] sec_tens, sec_ones;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       run;
        logic       pau;
        logic       wrn;
        logic       dn;
        logic       to;
        logic       dc;
    } exp_t;

    exp_t exp_q[$];

    // model state: 0 idle, 1 run, 2 pause, 3 done
    int m_st  = 0;
    int m_cnt = 0;
    bit m_dc  = 1'b0;
    bit m_to  = 1'b0;

    round_timer_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .div_clear(div_clear),
        .start(start), .pause_toggle(pause_toggle), .load_sec(load_sec),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running),
        .paused(paused), .warn(warn), .timeout(timeout), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_dc = 1'b0; m_to = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.tens = 4'(m_cnt / 10);
        e.ones = 4'(m_cnt % 10);
        e.run  = (m_st == 1);
        e.pau  = (m_st == 2);
        e.wrn  = ((m_st == 1) || (m_st == 2)) && (m_cnt >= 1) && (m_cnt <= 10);
        e.dn   = (m_st == 3);
        e.to   = m_to;
        e.dc   = m_dc;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input bit s, input bit p, input bit t, input int l);
        bit dc = 1'b0;
        bit to = 1'b0;
        int v;
        if (s) begin
            v = (l > 99) ? 99 : l;
            if (v != 0) begin
                m_st = 1; m_cnt = v; dc = 1'b1;
            end else begin
                m_st = 3; m_cnt = 0; to = 1'b1;
            end
        end else if (m_st == 1) begin
            if (t && !m_dc && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_st = 3; to = 1'b1;
                end else if (p) begin
                    m_st = 2;
                end
            end else if (p) begin
                m_st = 2;
            end
        end else if (m_st == 2 && p) begin
            m_st = 1; dc = 1'b1;
        end
        m_dc = dc;
        m_to = to;
    endtask

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk_eq("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk_eq("sec_tens", int'(sec_tens), int'(e.tens));
            chk_eq("sec_ones", int'(sec_ones), int'(e.ones));
            chk_eq("running", int'(running), int'(e.run));
            chk_eq("paused", int'(paused), int'(e.pau));
            chk_eq("warn", int'(warn), int'(e.wrn));
            chk_eq("done", int'(done), int'(e.dn));
            chk_eq("timeout", int'(timeout), int'(e.to));
            chk_eq("div_clear", int'(div_clear), int'(e.dc));
        end
    endtask

    task automatic step(input bit s, input bit p, input bit t, input int l);
        start = s; pause_toggle = p; tick = t; load_sec = 7'(l);
        @(posedge clk);
        model_step(s, p, t, l);
        push_expected();
        #1;
        compare_pop();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        push_expected();
        compare_pop();
        reset = 1'b0;

        // basic countdown 3 -> 0, ticks 10 cycles apart
        step(1, 0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            step(0, 0, 1, 0);
        end
        chk_eq("cd3_done", int'(done), 1);
        chk_eq("cd3_timeout", int'(timeout), 1);
        idle(1);
        chk_eq("cd3_timeout_1cyc", int'(timeout), 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);

        // clamp and BCD borrow
        step(1, 0, 0, 120);
        chk_eq("clamp_tens", int'(sec_tens), 9);
        chk_eq("clamp_ones", int'(sec_ones), 9);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk_eq("tick_98", int'(sec_ones), 8);
        step(1, 0, 0, 20);
        idle(1);
        step(0, 0, 1, 0);
        chk_eq("borrow_tens", int'(sec_tens), 1);
        chk_eq("borrow_ones", int'(sec_ones), 9);

        // pause / resume at 15
        step(1, 0, 0, 15);
        idle(2);
        step(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0);
        chk_eq("pause_hold", int'(sec_ones), 5);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        idle(2);
        step(0, 0, 1, 0);
        chk_eq("resume_14", int'(sec_ones), 4);

        // simultaneous tick + pause_toggle
        step(1, 0, 0, 5);
        idle(1);
        step(0, 1, 1, 0);
        chk_eq("tp_paused", int'(paused), 1);
        step(1, 0, 0, 1);
        idle(1);
        step(0, 1, 1, 0);
        chk_eq("tp_done_timeout", int'(timeout), 1);
        chk_eq("tp_done_paused", int'(paused), 0);

        // zero load, reload during run, start held, start with tick+pause
        step(1, 0, 0, 0);
        chk_eq("zero_load_dc", int'(div_clear), 0);
        step(1, 0, 0, 7);
        idle(1);
        step(1, 0, 1, 30);
        chk_eq("reload_tens", int'(sec_tens), 3);
        step(1, 0, 0, 25);
        step(1, 1, 1, 25);
        step(1, 0, 1, 8);
        idle(1);
        step(0, 0, 1, 0);
        idle(1);

        // asynchronous reset mid-count at 12
        step(1, 0, 0, 12);
        idle(1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        push_expected();
        compare_pop();
        @(posedge clk);
        #1;
        push_expected();
        compare_pop();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_expected();
        compare_pop();

        // fresh load after reset, full descent through warn window
        step(1, 0, 0, 11);
        for (int k = 0; k < 11; k++) begin
            idle(1);
            step(0, 0, 1, 0);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_timer_ctrl.md
# round_timer_ctrl

Countdown controller that sequences the seconds-tick divider for a game round. It loads a start value, restarts the tick divider so the first second is full length, and counts down one step per tick pulse. It supports pause/resume and reports the remaining time as two BCD digits for the 7-segment display path. It also raises a warning level near the end and a one-cycle timeout pulse at zero.

## Interface
- MAX_SEC, 99: upper clamp for the loaded value; legal range 1..99.
- WARN_SEC, 10: warn asserts while the remaining count is ≤ WARN_SEC and ≠ 0.

Ports:
- clk  in  1  system clock; all logic is on the posedge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- tick  in  1  one-cycle pulse from the seconds divider.
- div_clear  out  1  one-cycle pulse; drives the divider's reset to restart its period.
- start  in  1  level, sampled each cycle; load load_sec and run; restarts from any state.
- pause_toggle  in  1  one-cycle pulse, already debounced/one-pulsed upstream.
- load_sec  in  7  start value in binary, 0..127.
- sec_tens  out  4  remaining-time tens digit, BCD.
- sec_ones  out  4  remaining-time ones digit, BCD.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- warn  out  1  low-time indicator.
- timeout  out  1  one-cycle pulse when the count reaches 0.
- done  out  1  level; high in DONE.

## Operation
- States:
  - IDLE: reset state; digits hold 0.
  - RUN.
  - PAUSE.
  - DONE.
- The count is held as a BCD pair (tens, ones). A decrement with ones=0 sets ones=9 and decrements tens; the count never goes below 00.
- Load:
  - value = min(load_sec, MAX_SEC), converted to BCD (tens = value/10, ones = value%10; a combinational converter is acceptable).
  - value ≠ 0: enter RUN and pulse div_clear.
  - value = 0: enter DONE, pulse timeout, no div_clear.
- Transitions:
  - IDLE: start → load.
  - RUN, tick, count > 1: decrement.
  - RUN, tick, count = 1: count becomes 00, enter DONE, timeout=1 for one cycle.
  - RUN, pause_toggle: → PAUSE.
  - PAUSE: tick ignored.
  - PAUSE, pause_toggle: → RUN and pulse div_clear, so the resumed second is full length.
  - DONE: holds 00; start → load.
  - Any state, start: reload (restart), takes priority over tick and pause_toggle in the same cycle.
- Simultaneous tick and pause_toggle in RUN: apply the decrement first, then move to PAUSE. If that decrement reaches 0, go to DONE instead of PAUSE and still pulse timeout.
- A tick arriving in the same cycle that div_clear is high is ignored.
- pause_toggle in IDLE or DONE is ignored.
- warn = (RUN or PAUSE) and 1 ≤ count ≤ WARN_SEC.

## Timing
- All outputs are registered. Reset values:
  - state = IDLE.
  - sec_tens = 0, sec_ones = 0.
  - div_clear = 0, timeout = 0.
  - running = 0, paused = 0, warn = 0, done = 0.
- Start sampled at edge N: at N+1 the new digits are visible, running=1, and div_clear=1 for exactly one cycle.
- Tick sampled at edge N: the decremented digits are visible after edge N (1-cycle latency).
- Timeout asserts in the same cycle the digits first show 00 and DONE is entered, and is high for one cycle only.
- Reset mid-RUN or mid-PAUSE returns to IDLE asynchronously with no timeout pulse. The first start after reset behaves as a fresh load.
- start held high for several cycles re-loads every cycle, pulsing div_clear each cycle; the countdown begins after start falls.

## Test plan
- Reset, then start with load_sec=3, three ticks spaced 10 cycles apart → digits step 03, 02, 01, 00. After the 3rd tick: done=1, timeout pulses one cycle, warn drops to 0.
- load_sec=120, MAX_SEC=99 → digits 9/9, div_clear pulses once. One tick → 9/8. A tick with ones=0 at count 20 → 1/9.
- RUN at 15, pause_toggle → paused=1. Five ticks → digits stay 15. pause_toggle → running=1 and div_clear pulses. Next tick → 14.
- tick and pause_toggle in the same cycle at count 05 → PAUSE showing 04. Repeat at count 01 → DONE showing 00, timeout=1, paused=0.
- load_sec=0 → DONE at the next cycle, timeout pulse, no div_clear. start during RUN at 07 with load_sec=30 → reloads 30, div_clear pulses.
- reset asserted mid-count at 12 (asynchronously, between edges) → all outputs 0 immediately, no timeout. warn is 1 for counts 10..1 with default WARN_SEC.
